spi_xfer_arbiter: RTL and testbench

SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

---
 rtl/spi_defs_pkg.sv | 19 +
 rtl/spi_xfer_arbiter_rr_arbiter.sv | 28 ++
 rtl/spi_xfer_arbiter.sv | 179 +++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_defs_pkg.sv
// Shared SPI definitions: transfer FSM state encoding and default parameter values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_defs_pkg;

    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 1024;
    localparam int DEF_GAP_CYC     = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_GAP   = 3'd4
    } xfer_state_e;

endpackage

// File: rtl/spi_xfer_arbiter_rr_arbiter.sv
// Round-robin grant picker: first set request at or above ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is taken.
// Ports: req (request vector), ptr (highest-priority index), grant (one-hot, zero if no request).
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    // Walk priority offsets from lowest to highest priority so the
    // highest-priority hit is the last one written.
    always_comb begin
        grant = '0;
        for (int off = N - 1; off >= 0; off--) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && (((int'(ptr) + off) % N) == i)) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one spi_master among NUM_REQ requesters, one transfer at a time, round-robin.
// Latency: accept -> rsp_valid is 3 cycles plus the spi_master transfer time.
// Backpressure: requesters hold req_valid until req_ready; rsp_valid is a one-cycle pulse with no backpressure.
// Ports: req_valid/req_data/req_ready (requests), rsp_valid/rsp_data/rsp_err (responses),
//        m_start/m_tx_data/m_cs_sel/m_rx_data/m_done (spi_master side), busy (not IDLE).
module spi_xfer_arbiter
    import spi_defs_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      m_start,
    output logic [DATA_W-1:0]         m_tx_data,
    output logic [NUM_REQ-1:0]        m_cs_sel,
    input  logic [DATA_W-1:0]         m_rx_data,
    input  logic                      m_done,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    xfer_state_e         state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;         // owner of the transfer in flight
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]  cs_sel_q, cs_sel_d;
    logic                start_q, start_d;
    logic [NUM_REQ-1:0]  rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [PTR_W-1:0]    gnt_idx;
    logic [DATA_W-1:0]   sel_data;
    logic [CNT_W-1:0]    cnt_inc;
    logic                timeout_hit;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_gnt)
    );

    // Index and transmit word of the one-hot grant.
    always_comb begin
        gnt_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                gnt_idx  = PTR_W'(i);
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // cnt_q counts completed WAIT cycles; timeout fires on the cycle it would reach TIMEOUT_CYC.
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYC));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        tx_data_d  = tx_data_q;
        cs_sel_d   = cs_sel_q;
        start_d    = 1'b0;
        rsp_vld_d  = '0;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    gnt_d     = arb_gnt;
                    tx_data_d = sel_data;
                    cs_sel_d  = arb_gnt;
                    start_d   = 1'b1;
                    ptr_d     = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // m_done takes priority over a timeout in the same cycle.
                if (m_done) begin
                    rsp_data_d = m_rx_data;
                    rsp_err_d  = 1'b0;
                    rsp_vld_d  = gnt_q;
                    cs_sel_d   = '0;
                    state_d    = ST_RESP;
                end else if (timeout_hit) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    rsp_vld_d  = gnt_q;
                    cs_sel_d   = '0;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                gap_d   = '0;
                state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (int'(gap_q) >= GAP_CYC - 1) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cs_sel_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            tx_data_q  <= '0;
            cs_sel_q   <= '0;
            start_q    <= 1'b0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            tx_data_q  <= tx_data_d;
            cs_sel_q   <= cs_sel_d;
            start_q    <= start_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
        end
    end

    // The accept pulse is combinational so it lines up with the cycle the grant is taken.
    assign req_ready = (rst_n && (state_q == ST_IDLE)) ? arb_gnt : '0;
    assign rsp_valid = rsp_vld_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign m_start   = start_q;
    assign m_tx_data = tx_data_q;
    assign m_cs_sel  = cs_sel_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with NUM_REQ=2, DATA_W=8, TIMEOUT_CYC=16, GAP_CYC=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_xfer_arbiter;

    localparam int NR  = 2;
    localparam int DW  = 8;
    localparam int TO  = 16;
    localparam int GAP = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             rsp_err;
    logic             m_start;
    logic [DW-1:0]    m_tx_data;
    logic [NR-1:0]    m_cs_sel;
    logic [DW-1:0]    m_rx_data = '0;
    logic             m_done = 1'b0;
    logic             busy;

    int n_assert = 0;
    int n_fail   = 0;

    spi_xfer_arbiter #(
        .NUM_REQ     (NR),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO),
        .GAP_CYC     (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .m_start   (m_start),
        .m_tx_data (m_tx_data),
        .m_cs_sel  (m_cs_sel),
        .m_rx_data (m_rx_data),
        .m_done    (m_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_req_ready"}, 32'(req_ready), 32'h0);
        chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({pfx, "_rsp_data"},  32'(rsp_data),  32'h0);
        chk({pfx, "_rsp_err"},   32'(rsp_err),   32'h0);
        chk({pfx, "_m_start"},   32'(m_start),   32'h0);
        chk({pfx, "_m_tx_data"}, 32'(m_tx_data), 32'h0);
        chk({pfx, "_m_cs_sel"},  32'(m_cs_sel),  32'h0);
        chk({pfx, "_busy"},      32'(busy),      32'h0);
    endtask

    // One full transfer starting in IDLE with req_valid already driven.
    // done_at: WAIT cycle index that sees m_done, or -1 for a timeout.
    // hold: requester keeps req_valid high after being accepted.
    task automatic xfer(input logic [NR-1:0] g, input logic [DW-1:0] tx,
                        input logic [DW-1:0] rx, input int done_at, input bit hold);
        logic [DW-1:0] exp_data;
        logic          exp_err;
        int            k;
        exp_err  = (done_at < 0);
        exp_data = exp_err ? '0 : rx;

        #1;
        chk("idle_ready", 32'(req_ready), 32'(g));
        chk("idle_busy",  32'(busy),      32'h0);

        tick();
        if (!hold) req_valid = req_valid & ~g;
        #1;
        chk("start_pulse", 32'(m_start),   32'h1);
        chk("start_cs",    32'(m_cs_sel),  32'(g));
        chk("start_tx",    32'(m_tx_data), 32'(tx));
        chk("start_busy",  32'(busy),      32'h1);
        chk("start_ready", 32'(req_ready), 32'h0);

        tick();
        k = 0;
        while (1) begin
            chk("wait_start", 32'(m_start),   32'h0);
            chk("wait_cs",    32'(m_cs_sel),  32'(g));
            chk("wait_tx",    32'(m_tx_data), 32'(tx));
            chk("wait_rsp",   32'(rsp_valid), 32'h0);
            if (k == done_at) begin
                m_done    = 1'b1;
                m_rx_data = rx;
            end
            tick();
            m_done = 1'b0;
            if (k == done_at || k >= TO - 1) break;
            k++;
        end

        chk("resp_valid", 32'(rsp_valid), 32'(g));
        chk("resp_data",  32'(rsp_data),  32'(exp_data));
        chk("resp_err",   32'(rsp_err),   32'(exp_err));
        chk("resp_cs",    32'(m_cs_sel),  32'h0);
        chk("resp_busy",  32'(busy),      32'h1);

        // Spurious m_done during GAP must be ignored.
        tick();
        m_done    = 1'b1;
        m_rx_data = 8'hEE;
        chk("gap_valid", 32'(rsp_valid), 32'h0);
        chk("gap_cs",    32'(m_cs_sel),  32'h0);
        chk("gap_busy",  32'(busy),      32'h1);
        for (int i = 1; i < GAP; i++) begin
            tick();
            m_done = 1'b0;
            chk("gap_valid", 32'(rsp_valid), 32'h0);
            chk("gap_cs",    32'(m_cs_sel),  32'h0);
            chk("gap_busy",  32'(busy),      32'h1);
        end
        tick();
        chk("back_idle_busy",  32'(busy),      32'h0);
        chk("back_idle_valid", 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        // Reset; req_valid high to prove req_ready stays low while in reset.
        rst_n     = 1'b0;
        req_valid = 2'b01;
        tick();
        tick();
        #1;
        chk_all_zero("reset");
        req_valid = '0;
        rst_n     = 1'b1;
        tick();

        // Single request: A5 out, 3C back.
        req_data  = {8'h00, 8'hA5};
        req_valid = 2'b01;
        xfer(2'b01, 8'hA5, 8'h3C, 2, 1'b0);

        // Timeout: no m_done, 16 WAIT cycles, err=1 data=00.
        req_data  = {8'h00, 8'h5A};
        req_valid = 2'b01;
        xfer(2'b01, 8'h5A, 8'hFF, -1, 1'b0);

        // m_done on the timeout cycle wins.
        req_data  = {8'h00, 8'h77};
        req_valid = 2'b01;
        xfer(2'b01, 8'h77, 8'hC3, TO - 1, 1'b0);

        // Spurious m_done in IDLE.
        m_done    = 1'b1;
        m_rx_data = 8'h99;
        tick();
        m_done = 1'b0;
        chk("idle_done_busy",  32'(busy),      32'h0);
        chk("idle_done_valid", 32'(rsp_valid), 32'h0);
        chk("idle_done_start", 32'(m_start),   32'h0);
        tick();
        chk("idle_done_valid2", 32'(rsp_valid), 32'h0);

        // Reset in the middle of WAIT (ptr is 1 beforehand).
        req_data  = {8'h00, 8'h99};
        req_valid = 2'b01;
        #1;
        chk("rstw_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("rstw_cs_before", 32'(m_cs_sel), 32'h1);
        chk("rstw_busy_before", 32'(busy),   32'h1);
        rst_n     = 1'b0;
        m_done    = 1'b1;
        m_rx_data = 8'h55;
        tick();
        chk_all_zero("rst_mid");
        m_done = 1'b0;
        rst_n  = 1'b1;
        tick();
        chk("post_rst_valid", 32'(rsp_valid), 32'h0);
        chk("post_rst_busy",  32'(busy),      32'h0);

        // Contention from ptr=0: grants 0,1,0,1.
        req_data  = {8'h22, 8'h11};
        req_valid = 2'b11;
        xfer(2'b01, 8'h11, 8'hA1, 0, 1'b1);
        xfer(2'b10, 8'h22, 8'hB2, 3, 1'b1);
        xfer(2'b01, 8'h11, 8'hC3, 1, 1'b1);
        xfer(2'b10, 8'h22, 8'hD4, 0, 1'b1);
        req_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
